pixel_receive_interface: RTL and testbench
==========================================

Name: pixel_receive_interface

Overview:
Receiving end of the pixel transfer stream. Accepts raster-ordered pixels tagged with row/col under a valid/ready handshake. Checks the tags against its own expected raster position and writes each accepted pixel into a frame-buffer RAM through a registered write port. Sits between the pixel transfer source and the frame store that feeds the masking datapath.

Parameters:
IMAGE_WIDTH, 320, pixels per row (columns 0..IMAGE_WIDTH-1)
IMAGE_HEIGHT, 240, rows per frame (rows 0..IMAGE_HEIGHT-1)
PIXEL_W, 12, pixel colour width (4:4:4 RGB)
ROW_W, 8, row tag width
COL_W, 9, column tag width
ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMAGE_WIDTH*IMAGE_HEIGHT

Ports:
Clock  in  1  single clock; all state updates on rising edge
Reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; arms reception of one frame
pixel_in  in  PIXEL_W  pixel colour from the source
pix_row  in  ROW_W  row tag of pixel_in
pix_col  in  COL_W  column tag of pixel_in
pixel_valid  in  1  source presents a pixel
pixel_ready  out  1  block can accept; transfer occurs when pixel_valid && pixel_ready
wr_en  out  1  frame-buffer write strobe
wr_addr  out  ADDR_W  frame-buffer address, row*IMAGE_WIDTH+col
wr_data  out  PIXEL_W  frame-buffer write data
busy  out  1  high in RECV
frame_done  out  1  one-cycle pulse when the last pixel is written
frame_error  out  1  high while in ERR
pixel_count  out  ADDR_W  pixels accepted in the current frame

Behaviour:
- Reset (Reset_n=0, async): state=IDLE; pixel_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_error=0, pixel_count=0; expected row/col=0.
- States: IDLE, RECV, DONE, ERR.
- IDLE:
  - pixel_ready=0.
  - start -> RECV; clear expected row/col, address counter and pixel_count.
- RECV:
  - pixel_ready=1, busy=1; start is ignored.
  - On a transfer whose tags equal the expected row/col:
    - wr_en=1 next cycle, with wr_addr=current address counter and wr_data=pixel_in. Write latency is exactly 1 cycle.
    - Increment the address counter and pixel_count.
    - Column wraps at IMAGE_WIDTH-1 to 0; row increments on that wrap.
  - Address is generated by incrementing a counter; no multiplier.
  - Transfer at (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) -> DONE.
  - On a tag mismatch:
    - Drop the pixel (no write).
    - Move to ERR next cycle; pixel_ready is 0 from that cycle.
  - pixel_valid low: hold state; no write.
- DONE:
  - Lasts one cycle; pixel_ready=0.
  - frame_done=1 in the same cycle as the final wr_en.
  - Then -> IDLE. A start in DONE is ignored.
- ERR:
  - pixel_ready=0, frame_error=1; pixel_count frozen.
  - start -> RECV with full clear (same as from IDLE); frame_error drops the same edge.
- wr_en is never high for more than one cycle per accepted pixel; never high in IDLE or ERR except for the trailing write of a transfer accepted in the previous cycle.
- Tag compare is zero-extended to ROW_W/COL_W. Tags >= IMAGE_HEIGHT/IMAGE_WIDTH are always mismatches.
- Reset mid-frame: immediate return to IDLE; any pending write is discarded.

Decomposition:
- Shared package/include (alongside the existing utils include): IMAGE_WIDTH, IMAGE_HEIGHT, pixel/row/col/address widths, state encodings (IDLE=2'd0, RECV=2'd1, DONE=2'd2, ERR=2'd3).
- One natural sub-module, raster_position_tracker: holds expected row/col and the linear address counter, with inc/clear inputs and a last_pixel flag.

Test Plan (IMAGE_WIDTH=4, IMAGE_HEIGHT=3, ADDR_W=4 for sim):
1. Reset, then start, then 12 in-order pixels with data 0x100+n, valid continuous:
   - wr_en high 12 cycles, addresses 0..11, data 0x100..0x10B, one cycle after each transfer.
   - frame_done pulses with the address-11 write; pixel_count=12; back in IDLE.
2. Same stream with pixel_valid toggling 1/0:
   - Identical writes, gapped.
   - frame_done only after the 12th transfer.
3. Start, 5 good pixels, then a pixel tagged row=1, col=3 (expected row=1, col=1):
   - No write for that pixel; frame_error=1 and pixel_ready=0 next cycle; pixel_count=5.
   - A subsequent start clears the error and reception restarts at address 0.
4. Pixel tagged row=0, col=4 (out of range) as the first pixel:
   - Mismatch; ERR; no write.
5. Reset_n low after 7 pixels:
   - All outputs 0 asynchronously; no further writes.
   - After release, start and a full frame complete normally from address 0.
6. start pulsed in RECV, and pixel_valid high in IDLE:
   - start ignored; pixel_ready stays 0 in IDLE; no writes.

Source files
------------

// File: rtl/pixel_receive_interface_pkg.sv
// Shared constants and state encoding for the pixel receive path.
// The image geometry here is the production default; benches override it per instance.
package pixel_receive_interface_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int PIXEL_W      = 12;
  localparam int ROW_W        = 8;
  localparam int COL_W        = 9;
  localparam int ADDR_W       = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/pixel_receive_interface_if.sv
// Tagged pixel stream with a valid/ready handshake.
// A pixel moves only in a cycle where pixel_valid and pixel_ready are both high.
interface pixel_receive_interface_if #(
  parameter int PIXEL_W = pixel_receive_interface_pkg::PIXEL_W,
  parameter int ROW_W   = pixel_receive_interface_pkg::ROW_W,
  parameter int COL_W   = pixel_receive_interface_pkg::COL_W
);

  logic [PIXEL_W-1:0] pixel_in;
  logic [ROW_W-1:0]   pix_row;
  logic [COL_W-1:0]   pix_col;
  logic               pixel_valid;
  logic               pixel_ready;

  modport master (
    output pixel_in, pix_row, pix_col, pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_in, pix_row, pix_col, pixel_valid,
    output pixel_ready
  );

endinterface

// File: rtl/pixel_receive_interface_raster_position_tracker.sv
// Expected raster position and the linear frame-buffer address that walks with it.
// The address is advanced by one per accepted pixel, so no row*width multiply is needed.
module raster_position_tracker #(
  parameter int IMAGE_WIDTH  = pixel_receive_interface_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = pixel_receive_interface_pkg::IMAGE_HEIGHT,
  parameter int ROW_W        = pixel_receive_interface_pkg::ROW_W,
  parameter int COL_W        = pixel_receive_interface_pkg::COL_W,
  parameter int ADDR_W       = pixel_receive_interface_pkg::ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              clear,
  input  logic              inc,
  output logic [ROW_W-1:0]  exp_row,
  output logic [COL_W-1:0]  exp_col,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pixel
);

  logic col_at_end;

  assign col_at_end = (exp_col == COL_W'(IMAGE_WIDTH - 1));
  assign last_pixel = col_at_end && (exp_row == ROW_W'(IMAGE_HEIGHT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      exp_row <= '0;
      exp_col <= '0;
      addr    <= '0;
    end else if (clear) begin
      exp_row <= '0;
      exp_col <= '0;
      addr    <= '0;
    end else if (inc) begin
      addr <= addr + ADDR_W'(1);
      if (col_at_end) begin
        exp_col <= '0;
        exp_row <= exp_row + ROW_W'(1);
      end else begin
        exp_col <= exp_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_receive_interface.sv
// Receives one raster-ordered frame, checks each pixel's row/col tag against the
// expected position and writes accepted pixels to the frame buffer one cycle later.
module pixel_receive_interface
  import pixel_receive_interface_pkg::*;
#(
  parameter int IMAGE_WIDTH  = pixel_receive_interface_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = pixel_receive_interface_pkg::IMAGE_HEIGHT,
  parameter int PIXEL_W      = pixel_receive_interface_pkg::PIXEL_W,
  parameter int ROW_W        = pixel_receive_interface_pkg::ROW_W,
  parameter int COL_W        = pixel_receive_interface_pkg::COL_W,
  parameter int ADDR_W       = pixel_receive_interface_pkg::ADDR_W
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      start,
  pixel_receive_interface_if.slave  pix,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [PIXEL_W-1:0]        wr_data,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      frame_error,
  output logic [ADDR_W-1:0]         pixel_count
);

  rx_state_e         state;
  logic              ready_q;
  logic [ROW_W-1:0]  exp_row;
  logic [COL_W-1:0]  exp_col;
  logic [ADDR_W-1:0] addr;
  logic              last_pixel;
  logic              xfer;
  logic              tags_match;
  logic              accept;
  logic              restart;

  assign pix.pixel_ready = ready_q;

  // Out-of-range tags can never equal the expected position, so they fall out as mismatches.
  assign tags_match = (pix.pix_row == exp_row) && (pix.pix_col == exp_col);
  assign xfer       = pix.pixel_valid && ready_q && (state == RECV);
  assign accept     = xfer && tags_match;
  assign restart    = start && ((state == IDLE) || (state == ERR));

  // The address counter equals the number of pixels accepted so far in this frame.
  assign pixel_count = addr;

  raster_position_tracker #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .ROW_W        (ROW_W),
    .COL_W        (COL_W),
    .ADDR_W       (ADDR_W)
  ) u_tracker (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .clear      (restart),
    .inc        (accept),
    .exp_row    (exp_row),
    .exp_col    (exp_col),
    .addr       (addr),
    .last_pixel (last_pixel)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      wr_en      <= accept;
      frame_done <= 1'b0;
      if (accept) begin
        wr_addr <= addr;
        wr_data <= pix.pixel_in;
      end

      case (state)
        IDLE, ERR: begin
          if (start) begin
            state       <= RECV;
            ready_q     <= 1'b1;
            busy        <= 1'b1;
            frame_error <= 1'b0;
          end
        end
        RECV: begin
          if (xfer && !tags_match) begin
            state       <= ERR;
            ready_q     <= 1'b0;
            busy        <= 1'b0;
            frame_error <= 1'b1;
          end else if (accept && last_pixel) begin
            state      <= DONE;
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_receive_interface.sv
// Directed bench for pixel_receive_interface on a 4x3 image, compared each cycle
// against a frame-level model that tracks accepted-pixel count and raster position.
module tb_pixel_receive_interface;

  localparam int W       = 4;
  localparam int H       = 3;
  localparam int PIXEL_W = 12;
  localparam int ROW_W   = 8;
  localparam int COL_W   = 9;
  localparam int ADDR_W  = 4;

  logic               Clock = 1'b0;
  logic               Reset_n = 1'b1;
  logic               start = 1'b0;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PIXEL_W-1:0] wr_data;
  logic               busy;
  logic               frame_done;
  logic               frame_error;
  logic [ADDR_W-1:0]  pixel_count;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  pixel_receive_interface_if #(.PIXEL_W(PIXEL_W), .ROW_W(ROW_W), .COL_W(COL_W)) pix_if ();

  pixel_receive_interface #(
    .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .PIXEL_W(PIXEL_W),
    .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)
  ) dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .start       (start),
    .pix         (pix_if),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .pixel_count (pixel_count)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model: mode plus the number of pixels accepted so far.
  typedef enum int {M_IDLE, M_RECV, M_DONE, M_ERR} mode_e;
  mode_e mode = M_IDLE;
  int    n = 0;
  bit    m_wr_en = 0;
  bit    m_done = 0;
  int    m_wr_addr = 0;
  int    m_wr_data = 0;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mode = M_IDLE; n = 0; m_wr_en = 0; m_done = 0;
    end else begin
      m_wr_en = 0;
      m_done  = 0;
      case (mode)
        M_IDLE, M_ERR: if (start) begin mode = M_RECV; n = 0; end
        M_RECV: if (pix_if.pixel_valid) begin
          if (int'(pix_if.pix_row) == n / W && int'(pix_if.pix_col) == n % W) begin
            m_wr_en   = 1;
            m_wr_addr = n;
            m_wr_data = int'(pix_if.pixel_in);
            n++;
            if (n == W * H) begin mode = M_DONE; m_done = 1; end
          end else begin
            mode = M_ERR;
          end
        end
        M_DONE: mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge Clock) begin
    check("pixel_ready", 32'(pix_if.pixel_ready), 32'(mode == M_RECV));
    check("busy",        32'(busy),               32'(mode == M_RECV));
    check("frame_error", 32'(frame_error),        32'(mode == M_ERR));
    check("frame_done",  32'(frame_done),         32'(m_done));
    check("wr_en",       32'(wr_en),              32'(m_wr_en));
    check("pixel_count", 32'(pixel_count),        32'(n));
    if (m_wr_en) begin
      check("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
      check("wr_data", 32'(wr_data), 32'(m_wr_data));
    end
    if (wr_en) wr_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic send(input int r, input int c, input int d);
    pix_if.pixel_valid = 1'b1;
    pix_if.pix_row     = ROW_W'(r);
    pix_if.pix_col     = COL_W'(c);
    pix_if.pixel_in    = PIXEL_W'(d);
    @(negedge Clock);
  endtask

  task automatic idle(input int cycles);
    pix_if.pixel_valid = 1'b0;
    repeat (cycles) @(negedge Clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},       32'(wr_en),              0);
    check({tag, "_wr_addr"},     32'(wr_addr),            0);
    check({tag, "_wr_data"},     32'(wr_data),            0);
    check({tag, "_busy"},        32'(busy),               0);
    check({tag, "_done"},        32'(frame_done),         0);
    check({tag, "_error"},       32'(frame_error),        0);
    check({tag, "_count"},       32'(pixel_count),        0);
    check({tag, "_ready"},       32'(pix_if.pixel_ready), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_before;
    pix_if.pixel_valid = 1'b0;
    pix_if.pix_row = '0;
    pix_if.pix_col = '0;
    pix_if.pixel_in = '0;
    #1 Reset_n = 1'b0;
    repeat (2) @(negedge Clock);
    check_all_zero("reset");
    Reset_n = 1'b1;
    @(negedge Clock);

    // 1: continuous in-order frame
    pulse_start();
    for (int i = 0; i < W * H; i++) send(i / W, i % W, 'h100 + i);
    pix_if.pixel_valid = 1'b0;
    check("t1_done",  32'(frame_done),  1);
    check("t1_addr",  32'(wr_addr),     11);
    check("t1_data",  32'(wr_data),     'h10B);
    check("t1_count", 32'(pixel_count), 12);
    @(negedge Clock);
    check("t1_idle_busy", 32'(busy), 0);
    check("t1_writes", 32'(wr_cnt), 12);

    // 2: gapped valid
    pulse_start();
    for (int i = 0; i < W * H; i++) begin
      send(i / W, i % W, 'h100 + i);
      if (i == W * H - 1) check("t2_done_last", 32'(frame_done), 1);
      idle(1);
    end
    check("t2_writes", 32'(wr_cnt), 24);
    check("t2_dones",  32'(done_cnt), 2);

    // 3: tag mismatch after five good pixels, then restart from ERR
    pulse_start();
    for (int i = 0; i < 5; i++) send(i / W, i % W, 'h200 + i);
    send(1, 3, 'h2FF);
    check("t3_error", 32'(frame_error), 1);
    check("t3_ready", 32'(pix_if.pixel_ready), 0);
    check("t3_count", 32'(pixel_count), 5);
    check("t3_wr_en", 32'(wr_en), 0);
    idle(2);
    pulse_start();
    check("t3_err_clr", 32'(frame_error), 0);
    send(0, 0, 'h3A5);
    check("t3_re_addr", 32'(wr_addr), 0);
    check("t3_re_data", 32'(wr_data), 'h3A5);
    send(2, 2, 'h3A6);
    idle(1);

    // 4: out-of-range column as the very first pixel
    pulse_start();
    wr_before = wr_cnt;
    send(0, 4, 'h444);
    check("t4_error", 32'(frame_error), 1);
    check("t4_wr_en", 32'(wr_en), 0);
    idle(2);
    check("t4_no_write", 32'(wr_cnt), 32'(wr_before));

    // 5: reset mid-frame, then a clean frame
    pulse_start();
    for (int i = 0; i < 7; i++) send(i / W, i % W, 'h500 + i);
    pix_if.pixel_valid = 1'b0;
    #2 Reset_n = 1'b0;
    #1 check_all_zero("t5_async");
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    pulse_start();
    for (int i = 0; i < W * H; i++) send(i / W, i % W, 'h600 + i);
    check("t5_done", 32'(frame_done), 1);
    check("t5_data", 32'(wr_data), 'h60B);
    // start in DONE is ignored
    pix_if.pixel_valid = 1'b0;
    start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
    check("t5_done_start_ign", 32'(busy), 0);
    idle(1);

    // 6: start during RECV ignored; valid in IDLE ignored
    pulse_start();
    for (int i = 0; i < W * H; i++) begin
      if (i == 3) start = 1'b1;
      send(i / W, i % W, 'h700 + i);
      start = 1'b0;
      if (i == 3) check("t6_count_mid", 32'(pixel_count), 4);
    end
    pix_if.pixel_valid = 1'b0;
    @(negedge Clock);
    wr_before = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      send(0, 0, 'h7FF);
      check("t6_idle_ready", 32'(pix_if.pixel_ready), 0);
    end
    idle(2);
    check("t6_idle_writes", 32'(wr_cnt), 32'(wr_before));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
